// File: rtl/chromosome_load_sequencer.sv
// chromosome_load_sequencer: assembles a chromosome description from load words, drives the
// processing start/done handshake and presents captured error sums on a valid/ready result port.
//  iClock / iResetN          clock, asynchronous active-low reset
//  iClear                    abort partial load (LOAD) or drop result (RESULT)
//  iWordData/iWordValid      load word stream, oWordReady accepts
//  oChromDescription         assembled NUM_WORDS*WORD_W description
//  oStartProcessing          start request, iReadyToProcess accepts
//  iDoneProcessing           completion, iErrorSums captured on it
//  oDoneProcessingFeedback   one-cycle acknowledge of completion
//  oResultValid/iResultReady result handshake for oErrorSums/oTotalError
//  oChromCount               consumed results, wraps
//  oState                    LOAD=0, START=1, WAIT_DONE=2, RESULT=3
module chromosome_load_sequencer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 31,
  parameter int CNT_W     = 16
) (
  input  logic                        iClock,
  input  logic                        iResetN,
  input  logic                        iClear,
  input  logic [WORD_W-1:0]           iWordData,
  input  logic                        iWordValid,
  output logic                        oWordReady,
  output logic [NUM_WORDS*WORD_W-1:0] oChromDescription,
  output logic                        oStartProcessing,
  input  logic                        iReadyToProcess,
  input  logic                        iDoneProcessing,
  input  logic [7:0][31:0]            iErrorSums,
  output logic                        oDoneProcessingFeedback,
  output logic                        oResultValid,
  input  logic                        iResultReady,
  output logic [7:0][31:0]            oErrorSums,
  output logic [31:0]                 oTotalError,
  output logic [CNT_W-1:0]            oChromCount,
  output logic [1:0]                  oState
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  typedef enum logic [1:0] {LOAD = 2'd0, START = 2'd1, WAIT_DONE = 2'd2, RESULT = 2'd3} tState;
  tState state, nextState;
  logic [IDX_W-1:0] idx;
  logic wordFire, lastWord, doneFire;
  logic [34:0] sumAll;
  assign lastWord = idx == IDX_W'(NUM_WORDS - 1);
  // Clear has priority over a simultaneous word handshake.
  assign wordFire = state == LOAD && iWordValid && !iClear;
  assign doneFire = state == WAIT_DONE && iDoneProcessing;
  assign oState   = state;
  always_comb begin
    nextState        = state;
    oWordReady       = 1'b0;
    oStartProcessing = 1'b0;
    oResultValid     = 1'b0;
    case (state)
      LOAD: begin
        oWordReady = 1'b1;
        if (wordFire && lastWord) nextState = START;
      end
      START: begin
        oStartProcessing = 1'b1;
        if (iReadyToProcess) nextState = WAIT_DONE;
      end
      WAIT_DONE: if (iDoneProcessing) nextState = RESULT;
      RESULT: begin
        oResultValid = 1'b1;
        if (iClear || iResultReady) nextState = LOAD;
      end
      default: nextState = LOAD;
    endcase
  end
  // 35 bits hold the sum of eight 32-bit values without overflow.
  always_comb begin
    sumAll = '0;
    for (int i = 0; i < 8; i++) sumAll = sumAll + 35'(iErrorSums[i]);
  end
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state                   <= LOAD;
      idx                     <= '0;
      oChromDescription       <= '0;
      oErrorSums              <= '0;
      oTotalError             <= '0;
      oChromCount             <= '0;
      oDoneProcessingFeedback <= 1'b0;
    end else begin
      state                   <= nextState;
      oDoneProcessingFeedback <= doneFire;
      if (state == LOAD && iClear) idx <= '0;
      else if (wordFire) begin
        oChromDescription[idx*WORD_W +: WORD_W] <= iWordData;
        idx <= lastWord ? '0 : idx + 1'b1;
      end
      if (doneFire) begin
        oErrorSums  <= iErrorSums;
        oTotalError <= |sumAll[34:32] ? 32'hFFFF_FFFF : sumAll[31:0];
      end
      if (state == RESULT && iResultReady && !iClear) oChromCount <= oChromCount + 1'b1;
    end
  end
endmodule
